// File: rtl/rv_regfile_pkg.sv
// ============================================================================
// Module      : rv_regfile_pkg
// Description : Shared types and address helpers for the RV32 register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREGS_I  = 32;
  localparam int NREGS_E  = 16;

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [4:0]          reg_addr_t;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  function automatic logic addr_in_range(input reg_addr_t a, input int nregs);
    return 32'(a) < nregs;
  endfunction

  // x0 reads as zero and swallows writes, so it never counts as a real target.
  function automatic logic addr_legal(input reg_addr_t a, input int nregs);
    return (a != '0) && addr_in_range(a, nregs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_regfile_rdport.sv
// ============================================================================
// Module      : rv_regfile_rdport
// Description : One read port: zero/range masking plus optional same-cycle
//               write forwarding when RF_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_regfile_rdport
  import rv_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_I
) (
  input  logic            init_busy,
  input  reg_addr_t       rd_addr,
  input  logic [XLEN-1:0] rf_data,
`ifdef RF_BYPASS_EN
  input  logic            wr_en,
  input  reg_addr_t       wr_addr,
  input  logic [XLEN-1:0] wr_data,
`endif
  output logic [XLEN-1:0] rd_data
);

  always_comb begin
    rd_data = '0;
    if (!init_busy && addr_legal(rd_addr, NREGS)) begin
      rd_data = rf_data;
`ifdef RF_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv_regfile_np.sv
// ============================================================================
// Module      : rv_regfile_np
// Description : NRP-read / 1-write RV32 register file with post-reset zero
//               initialisation and sticky illegal-address flag.
//               Optional macro RF_BYPASS_EN enables write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_regfile_np
  import rv_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_I,
  parameter int NRP   = 2,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [NRP-1:0]    rd_en,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic              init_busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int IW = $clog2(NREGS);

  rf_state_e       state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] rf [NREGS];
  logic            wr_ok;
  logic            err_set;

  assign init_busy = (state == RF_INIT);
  assign wr_ok     = !init_busy && wr_en && addr_legal(wr_addr, NREGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_INIT;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == RF_INIT) begin
      cnt_nxt = cnt + AW'(1);
      if (32'(cnt) == NREGS - 1) state_nxt = RF_RUN;
    end
  end

  // Storage has no reset; the INIT sweep clears x1..x(NREGS-1) instead.
  always_ff @(posedge clk) begin
    if (init_busy)  rf[cnt[IW-1:0]]     <= '0;
    else if (wr_ok) rf[wr_addr[IW-1:0]] <= wr_data;
  end

  always_comb begin
    err_set = wr_en && !addr_in_range(wr_addr, NREGS);
    for (int p = 0; p < NRP; p++) begin
      if (rd_en[p] && !addr_in_range(rd_addr[p*AW +: AW], NREGS)) err_set = 1'b1;
    end
    if (init_busy) err_set = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rdport
    logic [AW-1:0] addr;
    assign addr = rd_addr[p*AW +: AW];

    rv_regfile_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_rdport (
      .init_busy (init_busy),
      .rd_addr   (addr),
      .rf_data   (rf[addr[IW-1:0]]),
`ifdef RF_BYPASS_EN
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
`endif
      .rd_data   (rd_data[p*XLEN +: XLEN])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_regfile_np.sv
// ============================================================================
// Module      : tb_rv_regfile_np
// Description : Self-checking bench for rv_regfile_np (RV32I and RV32E builds
//               side by side, shared stimulus); honours RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_regfile_np;

  localparam int NRP = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic [NRP-1:0]    rd_en;
  logic [NRP*5-1:0]  rd_addr;
  logic              err_clr;
  logic [NRP*32-1:0] rd_data32, rd_data16;
  logic              busy32, busy16, err32, err16;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rv_regfile_np #(.XLEN(32), .NREGS(32), .NRP(NRP), .AW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data32),
    .init_busy(busy32), .err(err32), .err_clr(err_clr)
  );

  rv_regfile_np #(.XLEN(32), .NREGS(16), .NRP(NRP), .AW(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data16),
    .init_busy(busy16), .err(err16), .err_clr(err_clr)
  );

  // Reference model: index 0 = 32-register build, index 1 = 16-register build.
  int          left [2];
  logic        merr [2];
  logic [31:0] mem  [2][32];

  function automatic int nr(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic logic [4:0] ra(input int p);
    return rd_addr[p*5 +: 5];
  endfunction

  function automatic logic illegal(input int d);
    logic hit;
    hit = wr_en && (int'(wr_addr) >= nr(d));
    for (int p = 0; p < NRP; p++)
      if (rd_en[p] && (int'(ra(p)) >= nr(d))) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
    if (left[d] > 0 || a == 5'd0 || int'(a) >= nr(d)) return '0;
`ifdef RF_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return mem[d][a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        left[d] <= nr(d) - 1;
        merr[d] <= 1'b0;
        for (int k = 0; k < 32; k++) mem[d][k] <= '0;
      end else if (left[d] > 0) begin
        left[d] <= left[d] - 1;
      end else begin
        if (illegal(d))   merr[d] <= 1'b1;
        else if (err_clr) merr[d] <= 1'b0;
        if (wr_en && wr_addr != 5'd0 && int'(wr_addr) < nr(d)) mem[d][wr_addr] <= wr_data;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy32", 32'(busy32), 32'(left[0] > 0));
      chk("busy16", 32'(busy16), 32'(left[1] > 0));
      chk("err32",  32'(err32),  32'(merr[0]));
      chk("err16",  32'(err16),  32'(merr[1]));
      for (int p = 0; p < NRP; p++) begin
        chk($sformatf("rd32_p%0d", p), rd_data32[p*32 +: 32], exp_rd(0, ra(p)));
        chk($sformatf("rd16_p%0d", p), rd_data16[p*32 +: 32], exp_rd(1, ra(p)));
      end
    end
  end

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = '0;   rd_addr = '0; err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setrd(input int p, input logic [4:0] a, input logic en);
    rd_addr[p*5 +: 5] = a;
    rd_en[p]          = en;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  // Counts negedges with init_busy high; also sweeps read addresses meanwhile.
  task automatic count_init(output int c32, output int c16);
    c32 = 0; c16 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy32) c32++;
      if (busy16) c16++;
      #1;
      setrd(0, 5'(i), 1'b0);
      setrd(1, 5'(31 - i), 1'b0);
      if (i == 10) wr_en = 1'b0;
    end
  endtask

  initial begin
    int c32, c16;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy32), 32'd1);
    chk("reset_err",  32'(err16),  32'd0);

    // Init timing, with a write during INIT that must be ignored.
    rst_n = 1'b1;
    wr(5'd5, 32'hDEAD_BEEF);
    count_init(c32, c16);
    chk("init_len32", 32'(c32), 32'd31);
    chk("init_len16", 32'(c16), 32'd15);
    idle();
    setrd(0, 5'd5, 1'b0); setrd(1, 5'd5, 1'b0);
    @(negedge clk);
    chk("x5_after_init32", rd_data32[31:0], 32'h0);
    chk("x5_after_init16", rd_data16[63:32], 32'h0);
    tick();

    // Basic write then read on both ports.
    wr(5'd7, 32'h1234_5678);
    setrd(0, 5'd7, 1'b1); setrd(1, 5'd7, 1'b1);
    @(negedge clk);
`ifndef RF_BYPASS_EN
    chk("x7_before", rd_data32[31:0], 32'h0);
`endif
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("x7_p0", rd_data32[31:0],  32'h1234_5678);
    chk("x7_p1", rd_data32[63:32], 32'h1234_5678);
    chk("x7_e",  rd_data16[63:32], 32'h1234_5678);
    tick();
    wr(5'd0, 32'hFFFF_FFFF);
    setrd(0, 5'd0, 1'b1); setrd(1, 5'd0, 1'b1);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("x0_read", rd_data32[31:0], 32'h0);
    chk("x0_err",  32'(err16), 32'd0);
    tick();

    // Same-cycle write/read of x3.
    wr(5'd3, 32'hA);
    tick();
    wr(5'd3, 32'hB);
    setrd(0, 5'd3, 1'b1);
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("x3_same_cycle", rd_data32[31:0], 32'hB);
`else
    chk("x3_same_cycle", rd_data32[31:0], 32'hA);
`endif
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("x3_next", rd_data32[31:0], 32'hB);
    tick();

    // RV32E range errors.
    wr(5'd4, 32'h44);
    tick();
    wr(5'd20, 32'h55);
    setrd(0, 5'd4, 1'b0); setrd(1, 5'd4, 1'b0);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("e_err_wr",   32'(err16), 32'd1);
    chk("i_err_wr",   32'(err32), 32'd0);
    chk("e_x4_keep",  rd_data16[31:0], 32'h44);
    chk("i_x20",      32'(rd_data32[31:0] == 32'h44), 32'd1);
    tick();
    setrd(1, 5'd17, 1'b1);
    @(negedge clk);
    chk("e_x17_zero", rd_data16[63:32], 32'h0);
    tick();
    setrd(1, 5'd17, 1'b0);
    @(negedge clk);
    chk("e_err_hold", 32'(err16), 32'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("e_err_clr", 32'(err16), 32'd0);
    tick();
    err_clr = 1'b1;
    setrd(0, 5'd31, 1'b1);
    tick();
    err_clr = 1'b0;
    setrd(0, 5'd31, 1'b0);
    @(negedge clk);
    chk("e_set_wins", 32'(err16), 32'd1);
    chk("i_no_err",   32'(err32), 32'd0);
    tick();

    // Reset in the middle of INIT.
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_init(c32, c16);
    chk("reinit_len32", 32'(c32), 32'd31);
    chk("reinit_len16", 32'(c16), 32'd15);
    idle();
    setrd(0, 5'd7, 1'b0); setrd(1, 5'd4, 1'b0);
    @(negedge clk);
    chk("reinit_x7", rd_data32[31:0],  32'h0);
    chk("reinit_x4", rd_data16[63:32], 32'h0);
    chk("reinit_err", 32'(err16), 32'd0);
    tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom % 2) == 0;
      wr_addr = (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'($urandom % 16);
      wr_data = (($urandom % 4) == 0) ? 32'($urandom % 16) : $urandom;
      for (int p = 0; p < NRP; p++)
        setrd(p, (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'($urandom % 16),
              ($urandom % 4) == 0);
      err_clr = ($urandom % 8) == 0;
      rst_n   = ($urandom % 400) != 0;
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
